// File: rtl/au_arith_pkg.sv
// Shared arithmetic helpers: borrow-slice geometry and the per-stage control payload.
package au_arith_pkg;

  function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned width, input int unsigned stages,
                                           input int unsigned k);
    return k * slice_width(width, stages);
  endfunction

  // Number of operand bits owned by slice k; 0 means the stage is a pure delay.
  function automatic int unsigned slice_len(input int unsigned width, input int unsigned stages,
                                            input int unsigned k);
    int unsigned lo;
    int unsigned hi;
    lo = slice_lo(width, stages, k);
    if (lo >= width) return 0;
    hi = lo + slice_width(width, stages);
    if (hi > width) hi = width;
    return hi - lo;
  endfunction

  typedef struct packed {
    logic valid;
    logic borrow;
    logic zacc;
    logic ovf;
  } stage_ctl_t;

endpackage

// File: rtl/au_sub_vz_pipe_if.sv
// Operand/result valid-ready bus for au_sub_vz_pipe; bo exists only with AU_SUB_VZ_PIPE_BO_EN.
interface au_sub_vz_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             v;
  logic             z;
`ifdef AU_SUB_VZ_PIPE_BO_EN
  logic             bo;
`endif

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, v, z
`ifdef AU_SUB_VZ_PIPE_BO_EN
    , input bo
`endif
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, v, z
`ifdef AU_SUB_VZ_PIPE_BO_EN
    , output bo
`endif
  );
endinterface

// File: rtl/au_sub_slice.sv
// Combinational N-bit a - b - bi slice with borrow-out, zero and MSB borrow-in.
module au_sub_slice #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bi,
  output logic [N-1:0] d,
  output logic         bo,
  output logic         zero,
  output logic         msb_bi
);
  localparam int unsigned TW = N + 1;

  logic [N:0] t;

  assign t      = {1'b0, a} - {1'b0, b} - TW'(bi);
  assign d      = t[N-1:0];
  assign bo     = t[N];
  assign zero   = ~|t[N-1:0];
  // Sum bit = a ^ b ^ borrow-in, so the MSB borrow-in falls out of the result bit.
  assign msb_bi = a[N-1] ^ b[N-1] ^ t[N-1];
endmodule

// File: rtl/au_sub_vz_pipe.sv
// Pipelined s = a - b - ci with V/Z flags, one borrow slice per stage, full backpressure.
// Optional unsigned borrow-out port bo under AU_SUB_VZ_PIPE_BO_EN.
module au_sub_vz_pipe
  import au_arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic             clk,
  input logic             rst_n,
  au_sub_vz_pipe_if.slave bus
);
  stage_ctl_t       ctl_w [STAGES+1];
  logic [WIDTH-1:0] res_w [STAGES+1];
  logic [WIDTH-1:0] a_w   [STAGES];
  logic [WIDTH-1:0] b_w   [STAGES];
  logic             en;

  assign en           = !ctl_w[STAGES].valid || bus.out_ready;
  assign bus.in_ready = en;

  assign ctl_w[0] = '{valid: bus.in_valid, borrow: bus.ci, zacc: 1'b1, ovf: 1'b0};
  assign res_w[0] = '0;
  assign a_w[0]   = bus.a;
  assign b_w[0]   = bus.b;

  assign bus.out_valid = ctl_w[STAGES].valid;
  assign bus.s         = res_w[STAGES];
  assign bus.v         = ctl_w[STAGES].ovf;
  assign bus.z         = ctl_w[STAGES].zacc;
`ifdef AU_SUB_VZ_PIPE_BO_EN
  assign bus.bo        = ctl_w[STAGES].borrow;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO      = slice_lo(WIDTH, STAGES, k);
    localparam int unsigned N       = slice_len(WIDTH, STAGES, k);
    localparam int unsigned NW      = (N > 0) ? N : 1;
    localparam bit          LAST    = (k == STAGES - 1);
    localparam bit          HAS_MSB = (N > 0) && (LO + N == WIDTH);

    logic [NW-1:0]    sl_d;
    logic             sl_bo;
    logic             sl_zero;
    logic             sl_msb_bi;
    stage_ctl_t       ctl_d;
    stage_ctl_t       ctl_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;

    if (N > 0) begin : g_slice
      au_sub_slice #(.N(N)) u_slice (
        .a      (NW'(a_w[k] >> LO)),
        .b      (NW'(b_w[k] >> LO)),
        .bi     (ctl_w[k].borrow),
        .d      (sl_d),
        .bo     (sl_bo),
        .zero   (sl_zero),
        .msb_bi (sl_msb_bi)
      );
    end else begin : g_delay
      assign sl_d      = '0;
      assign sl_bo     = ctl_w[k].borrow;
      assign sl_zero   = 1'b1;
      assign sl_msb_bi = 1'b0;
    end

    // The 2^WIDTH wrap (s == 0 with overflow) is not a true zero, hence the final ~ovf mask.
    always_comb begin
      ctl_d        = ctl_w[k];
      ctl_d.borrow = sl_bo;
      ctl_d.zacc   = ctl_w[k].zacc & sl_zero;
      if (HAS_MSB) ctl_d.ovf = sl_msb_bi ^ sl_bo;
      if (LAST) ctl_d.zacc = ctl_d.zacc & ~ctl_d.ovf;
      res_d        = res_w[k] | (WIDTH'(sl_d) << LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        res_q <= '0;
      end else if (en) begin
        ctl_q <= ctl_d;
        res_q <= res_d;
      end
    end

    assign ctl_w[k+1] = ctl_q;
    assign res_w[k+1] = res_q;

    if (!LAST) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_w[k];
          b_q <= b_w[k];
        end
      end

      assign a_w[k+1] = a_q;
      assign b_w[k+1] = b_q;
    end
  end
endmodule

// File: tb/tb_au_sub_vz_pipe.sv
// Self-checking bench for au_sub_vz_pipe at (8,2), (7,3) and (1,1); checks bo under AU_SUB_VZ_PIPE_BO_EN.
module tb_au_sub_vz_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        v;
    logic        z;
    logic        bo;
  } exp_t;

  au_sub_vz_pipe_if #(.WIDTH(8)) bus8();
  au_sub_vz_pipe_if #(.WIDTH(7)) bus7();
  au_sub_vz_pipe_if #(.WIDTH(1)) bus1();

  au_sub_vz_pipe #(.WIDTH(8), .STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  au_sub_vz_pipe #(.WIDTH(7), .STAGES(3)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));
  au_sub_vz_pipe #(.WIDTH(1), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [31:0] va [$];
  logic [31:0] vb [$];
  logic        vc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // T = sext(a) - sext(b) - ci over w+1 bits
  function automatic exp_t ref_sub(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci);
    exp_t   r;
    longint mask, lim, ua, ub, sa, sb, t;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    t    = sa - sb - longint'(ci);
    r.s  = 32'(t & mask);
    r.v  = (t < -lim) || (t > lim - 1);
    r.z  = (t == 0);
    r.bo = (ua < ub + longint'(ci));
    return r;
  endfunction

  task automatic check_res(input string tag, input exp_t got, input exp_t exp);
    check({tag, ".s"}, got.s, exp.s);
    check({tag, ".v"}, 32'(got.v), 32'(exp.v));
    check({tag, ".z"}, 32'(got.z), 32'(exp.z));
`ifdef AU_SUB_VZ_PIPE_BO_EN
    check({tag, ".bo"}, 32'(got.bo), 32'(exp.bo));
`endif
  endtask

  function automatic exp_t obs8();
    exp_t r;
    r.s = 32'(bus8.s); r.v = bus8.v; r.z = bus8.z;
`ifdef AU_SUB_VZ_PIPE_BO_EN
    r.bo = bus8.bo;
`else
    r.bo = 1'b0;
`endif
    return r;
  endfunction

  function automatic exp_t obs_sm(input int w);
    exp_t r;
    if (w == 7) begin
      r.s = 32'(bus7.s); r.v = bus7.v; r.z = bus7.z;
`ifdef AU_SUB_VZ_PIPE_BO_EN
      r.bo = bus7.bo;
`else
      r.bo = 1'b0;
`endif
    end else begin
      r.s = 32'(bus1.s); r.v = bus1.v; r.z = bus1.z;
`ifdef AU_SUB_VZ_PIPE_BO_EN
      r.bo = bus1.bo;
`else
      r.bo = 1'b0;
`endif
    end
    return r;
  endfunction

  task automatic drive_sm(input int w, input logic vld, input logic [31:0] a, input logic [31:0] b,
                          input logic ci);
    if (w == 7) begin
      bus7.in_valid = vld; bus7.a = 7'(a); bus7.b = 7'(b); bus7.ci = ci;
    end else begin
      bus1.in_valid = vld; bus1.a = 1'(a); bus1.b = 1'(b); bus1.ci = ci;
    end
  endtask

  // One beat through the 8-bit pipe with an idle downstream; checks latency and result.
  task automatic directed8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input logic [7:0] es, input logic ev, input logic ez, input logic eb);
    exp_t e;
    int   lat;
    e = '{s: 32'(es), v: ev, z: ez, bo: eb};
    @(negedge clk);
    bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
    bus8.a = a; bus8.b = b; bus8.ci = ci;
    #1 check({tag, ".in_ready"}, 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'd2);
    check_res(tag, obs8(), e);
  endtask

  // Random stream into the 8-bit pipe with an optional out_ready=0 window.
  task automatic stream8(input string tag, input int n, input int stall_at, input int stall_len);
    exp_t       q [$];
    int         sent, got, cyc, first, last;
    logic [7:0] ra, rb;
    logic       rc;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
    while (got < n && cyc < n + stall_len + 20) begin
      @(negedge clk);
      bus8.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      bus8.in_valid  = (sent < n);
      bus8.a = ra; bus8.b = rb; bus8.ci = rc;
      #1;
      if (bus8.out_valid) begin
        if (q.size() == 0) begin
          check({tag, ".qsize"}, 32'(q.size()), 32'd1);
        end else if (!bus8.out_ready) begin
          check({tag, ".stall_in_ready"}, 32'(bus8.in_ready), 32'd0);
          check_res({tag, ".hold"}, obs8(), q[0]);
        end else begin
          check_res(tag, obs8(), q.pop_front());
          got++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q.push_back(ref_sub(8, 32'(ra), 32'(rb), rc));
        sent++;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    check({tag, ".count"}, 32'(got), 32'(n));
    if (stall_len == 0) check({tag, ".rate"}, 32'(last - first), 32'(n - 1));
  endtask

  // Stream into the 7-bit or 1-bit pipe: va/vb/vc vectors first, then random beats.
  task automatic stream_sm(input string tag, input int w, input int n, input int stages);
    exp_t        q [$];
    int          sent, got, cyc, first;
    logic [31:0] ra, rb, mask;
    logic        rc;
    sent = 0; got = 0; cyc = 0; first = -1;
    mask = (32'd1 << w) - 32'd1;
    while (got < n && cyc < n + 20) begin
      @(negedge clk);
      if (sent < n) begin
        if (sent < va.size()) begin
          ra = va[sent]; rb = vb[sent]; rc = vc[sent];
        end else begin
          ra = $urandom & mask; rb = $urandom & mask; rc = 1'($urandom_range(0, 1));
        end
        drive_sm(w, 1'b1, ra, rb, rc);
        q.push_back(ref_sub(w, ra, rb, rc));
        sent++;
      end else begin
        drive_sm(w, 1'b0, 32'd0, 32'd0, 1'b0);
      end
      #1;
      if ((w == 7) ? bus7.out_valid : bus1.out_valid) begin
        if (first < 0) first = cyc;
        check_res(tag, obs_sm(w), q.pop_front());
        got++;
      end
      cyc++;
    end
    check({tag, ".count"}, 32'(got), 32'(n));
    check({tag, ".lat"}, 32'(first), 32'(stages));
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0; bus8.out_ready = 1'b0;
    bus7.in_valid = 1'b0; bus7.a = '0; bus7.b = '0; bus7.ci = 1'b0; bus7.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0; bus1.out_ready = 1'b1;

    #3;
    check("rst.out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst.in_ready", 32'(bus8.in_ready), 32'd1);
    check_res("rst", obs8(), '{s: 32'd0, v: 1'b0, z: 1'b0, bo: 1'b0});
    check("rst7.out_valid", 32'(bus7.out_valid), 32'd0);
    check("rst1.out_valid", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    directed8("eq",           8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    directed8("eq_ci",        8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    directed8("neg_ovf",      8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0);
    directed8("pos_ovf",      8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    directed8("wrap_zero",    8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    directed8("zero_ci",      8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    directed8("slice_borrow", 8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0, 1'b0);

    stream8("stream", 16, 0, 0);
    stream8("stall", 16, 6, 5);

    // Two beats in flight, then an asynchronous reset between clock edges.
    @(negedge clk);
    bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
    bus8.a = 8'h10; bus8.b = 8'h01; bus8.ci = 1'b0;
    @(negedge clk);
    bus8.a = 8'h20; bus8.b = 8'h02; bus8.ci = 1'b0;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    check("pre_rst.out_valid", 32'(bus8.out_valid), 32'd1);
    check_res("pre_rst", obs8(), '{s: 32'h0F, v: 1'b0, z: 1'b0, bo: 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(bus8.out_valid), 32'd0);
    check("mid_rst.in_ready", 32'(bus8.in_ready), 32'd1);
    check_res("mid_rst", obs8(), '{s: 32'd0, v: 1'b0, z: 1'b0, bo: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    directed8("post_rst", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("post_rst.drained", 32'(bus8.out_valid), 32'd0);

    va = '{32'h00, 32'h40, 32'h3F, 32'h40, 32'h7F};
    vb = '{32'h00, 32'h01, 32'h7F, 32'h3F, 32'h7F};
    vc = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
    stream_sm("w7", 7, 64, 3);

    va = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
    vb = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
    vc = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    stream_sm("w1", 1, 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
